remote_key_filter: RTL and testbench

REMOTE_KEY_FILTER -- requirements
Module: remote_key_filter

---
 rtl/remote_pkg.sv | 22 ++
 rtl/remote_key_filter_if.sv | 15 +
 rtl/remote_sync2.sv | 27 ++
 rtl/remote_key_filter.sv | 129 ++++++++++++
 tb/tb_remote_key_filter.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/remote_pkg.sv
// Shared definitions for the remote key filter.
//   state_t      : debounce FSM states
//   KEY_NONE     : active-low pattern meaning "no key pressed"
//   SYNC_DEPTH   : number of synchronizer flops ahead of the FSM
//   is_single_key: true when exactly one active-low bit is asserted
package remote_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    DEBOUNCE     = 2'd1,
    ACCEPT       = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_t;

  localparam logic [7:0] KEY_NONE   = 8'hFF;
  localparam int         SYNC_DEPTH = 2;

  function automatic logic is_single_key(input logic [7:0] v);
    return $countones(~v) == 1;
  endfunction

endpackage

// File: rtl/remote_key_filter_if.sv
// Key filter bus: raw remote buttons in, accepted key out.
//   in_hex_raw : raw active-low buttons ([7:4] player 1, [3:0] player 2)
//   out_hex    : accepted active-low key, 8'hFF when none
//   out_valid  : high while out_hex carries an accepted key
// master = stimulus/producer side, slave = filter side.
interface remote_key_filter_if;

  logic [7:0] in_hex_raw;
  logic [7:0] out_hex;
  logic       out_valid;

  modport master (output in_hex_raw, input out_hex, input out_valid);
  modport slave  (input in_hex_raw, output out_hex, output out_valid);

endinterface

// File: rtl/remote_sync2.sv
// Multi-flop synchronizer for the asynchronous remote button bus.
// Resets to KEY_NONE so that a reset never looks like a press.
//   clk, rst : clock and synchronous active-high reset
//   d        : asynchronous 8-bit input
//   q        : synchronized output (last flop)
module remote_sync2
  import remote_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] d,
  output logic [7:0] q
);

  logic [SYNC_DEPTH-1:0][7:0] sync_pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_pipe <= {SYNC_DEPTH{KEY_NONE}};
    end else begin
      sync_pipe <= {sync_pipe[SYNC_DEPTH-2:0], d};
    end
  end

  assign q = sync_pipe[SYNC_DEPTH-1];

endmodule

// File: rtl/remote_key_filter.sv
// Remote key filter: synchronizes raw active-low buttons, debounces a
// single key press and reports each press exactly once.
//   clk, rst   : clock and synchronous active-high reset
//   bus.slave  : in_hex_raw in, out_hex / out_valid out
// Parameter DEBOUNCE_CYCLES : stable samples required for press and release.
// Macro REMOTE_HOLD_EN : when defined, the accepted key is held on the
// outputs through WAIT_RELEASE until the sample first differs from it;
// otherwise out_valid is a one-cycle pulse.
module remote_key_filter
  import remote_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input logic               clk,
  input logic               rst,
  remote_key_filter_if.slave bus
);

  localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

  logic [7:0]  s;
  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [15:0] rel_cnt, rel_cnt_nxt;
  logic [7:0]  cand, cand_nxt;
  logic [7:0]  out_hex_r, out_hex_nxt;
  logic        out_valid_r, out_valid_nxt;

  remote_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.in_hex_raw),
    .q   (s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      rel_cnt     <= '0;
      cand        <= KEY_NONE;
      out_hex_r   <= KEY_NONE;
      out_valid_r <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      rel_cnt     <= rel_cnt_nxt;
      cand        <= cand_nxt;
      out_hex_r   <= out_hex_nxt;
      out_valid_r <= out_valid_nxt;
    end
  end

  // Outputs are registered: they are loaded on the same edge the FSM
  // enters ACCEPT, so out_valid and state==ACCEPT coincide.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    rel_cnt_nxt   = rel_cnt;
    cand_nxt      = cand;
    out_hex_nxt   = KEY_NONE;
    out_valid_nxt = 1'b0;

    unique case (state)
      IDLE: begin
        if (is_single_key(s)) begin
          cand_nxt  = s;
          cnt_nxt   = '0;
          state_nxt = DEBOUNCE;
        end else if (s != KEY_NONE) begin
          // Simultaneous presses are never reported; wait for a clean release.
          rel_cnt_nxt = '0;
          state_nxt   = WAIT_RELEASE;
        end
      end

      DEBOUNCE: begin
        if (s == cand) begin
          if (cnt == CNT_LAST) begin
            state_nxt     = ACCEPT;
            out_hex_nxt   = cand;
            out_valid_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + 16'd1;
          end
        end else begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
      end

      ACCEPT: begin
        rel_cnt_nxt = '0;
        state_nxt   = WAIT_RELEASE;
`ifdef REMOTE_HOLD_EN
        out_hex_nxt   = out_hex_r;
        out_valid_nxt = out_valid_r;
`endif
      end

      WAIT_RELEASE: begin
        if (s == KEY_NONE) begin
          if (rel_cnt == CNT_LAST) begin
            rel_cnt_nxt = '0;
            state_nxt   = IDLE;
          end else begin
            rel_cnt_nxt = rel_cnt + 16'd1;
          end
        end else begin
          rel_cnt_nxt = '0;
        end
`ifdef REMOTE_HOLD_EN
        // Once the sample leaves the accepted key the hold drops for good,
        // because out_valid_r is then 0 and can no longer re-arm it.
        if (out_valid_r && (s == cand)) begin
          out_hex_nxt   = out_hex_r;
          out_valid_nxt = 1'b1;
        end
`endif
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign bus.out_hex   = out_hex_r;
  assign bus.out_valid = out_valid_r;

endmodule

// File: tb/tb_remote_key_filter.sv
// Self-checking bench for remote_key_filter: directed scenarios plus a
// randomized phase, all compared every cycle against a run-length model.
module tb_remote_key_filter;
  import remote_pkg::*;

  localparam int DEB = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;

  remote_key_filter_if bus ();

  remote_key_filter #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a 2-sample delay line for the synchronizer, then
  // press acceptance expressed as run lengths of identical samples.
  logic [7:0] m_s1 = KEY_NONE, m_s2 = KEY_NONE;
  bit         m_armed = 1'b1;   // ready to accept a new press
  int         m_run   = 0;      // length of current single-key run
  logic [7:0] m_key   = KEY_NONE;
  int         m_ff    = 0;      // consecutive idle samples while locked
  bit         m_skip  = 1'b0;   // the cycle right after acceptance ignores its sample
  logic [7:0] m_hex   = KEY_NONE;
  bit         m_valid = 1'b0;

  task automatic model_step(input logic r, input logic [7:0] raw);
    logic [7:0] smp;
    bit pulse, was_skip, was_locked;
    if (r) begin
      m_s1 = KEY_NONE; m_s2 = KEY_NONE;
      m_armed = 1'b1; m_run = 0; m_key = KEY_NONE; m_ff = 0; m_skip = 1'b0;
      m_hex = KEY_NONE; m_valid = 1'b0;
      return;
    end
    smp = m_s2;
    m_s2 = m_s1;
    m_s1 = raw;
    pulse = 1'b0;
    was_skip = m_skip;
    was_locked = !m_armed;
    if (m_armed) begin
      if (m_run == 0) begin
        if ($countones(~smp) == 1) begin
          m_key = smp;
          m_run = 1;
        end else if (smp != KEY_NONE) begin
          m_armed = 1'b0; m_ff = 0; m_skip = 1'b0;
        end
      end else if (smp == m_key) begin
        m_run++;
        if (m_run == DEB + 1) begin
          pulse = 1'b1;
          m_armed = 1'b0; m_ff = 0; m_skip = 1'b1; m_run = 0;
        end
      end else begin
        m_run = 0;
      end
    end else if (m_skip) begin
      m_skip = 1'b0;
    end else begin
      if (smp == KEY_NONE) begin
        m_ff++;
        if (m_ff == DEB) begin
          m_armed = 1'b1; m_ff = 0;
        end
      end else begin
        m_ff = 0;
      end
    end
`ifdef REMOTE_HOLD_EN
    if (pulse) begin
      m_valid = 1'b1; m_hex = m_key;
    end else if (!(m_valid && was_locked && (was_skip || smp == m_key))) begin
      m_valid = 1'b0; m_hex = KEY_NONE;
    end
`else
    m_valid = pulse;
    m_hex   = pulse ? m_key : KEY_NONE;
`endif
  endtask

  bit         chk_en = 1'b0;
  bit         prev_valid = 1'b0;
  int         edge_no = 0;
  int         rises = 0;
  int         first_edge = -1;
  int         last_edge = -1;
  logic [7:0] first_hex = KEY_NONE;

  task automatic tick();
    logic r;
    logic [7:0] raw;
    @(posedge clk);
    r = rst;
    raw = bus.in_hex_raw;
    model_step(r, raw);
    if (r) chk_en = 1'b1;
    #1;
    edge_no++;
    if (chk_en) begin
      check_val("out_valid", {15'b0, bus.out_valid}, {15'b0, m_valid});
      check_val("out_hex", {8'b0, bus.out_hex}, {8'b0, m_hex});
    end
    if (bus.out_valid === 1'b1) begin
      if (!prev_valid) begin
        rises++;
        first_edge = edge_no;
        first_hex = bus.out_hex;
      end
      last_edge = edge_no;
    end
    prev_valid = (bus.out_valid === 1'b1);
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic start_win();
    edge_no = 0; rises = 0; first_edge = -1; last_edge = -1; first_hex = KEY_NONE;
  endtask

  task automatic idle_gap();
    bus.in_hex_raw = KEY_NONE;
    run(2 * DEB + 8);
  endtask

  int base;
  int seg_len;
  int pick;
  logic [7:0] one_hot;
  logic [7:0] multi;

  initial begin
    // Reset held with a key down
    bus.in_hex_raw = 8'hFE;
    rst = 1'b1;
    run(3);
    check_val("rst_hex", {8'b0, bus.out_hex}, 16'h00FF);
    check_val("rst_valid", {15'b0, bus.out_valid}, 16'h0000);
    rst = 1'b0;
    start_win();
    run(40);
    check_val("rst_rel_pulses", 16'(rises), 16'd1);
    check_val("rst_rel_edge", 16'(first_edge), 16'(DEB + 3));
    check_val("rst_rel_hex", {8'b0, first_hex}, 16'h00FE);
    idle_gap();

    // Clean press
    bus.in_hex_raw = 8'hEF;
    start_win();
    run(40);
    check_val("clean_pulses", 16'(rises), 16'd1);
    check_val("clean_edge", 16'(first_edge), 16'(DEB + 3));
    check_val("clean_hex", {8'b0, first_hex}, 16'h00EF);
`ifdef REMOTE_HOLD_EN
    check_val("clean_hold_end", 16'(last_edge), 16'd40);
`else
    check_val("clean_width", 16'(last_edge), 16'(first_edge));
`endif
    idle_gap();

    // Bounce
    start_win();
    for (int t = 0; t < 4; t++) begin
      bus.in_hex_raw = (t % 2 == 0) ? 8'hFE : 8'hFF;
      run(3);
    end
    base = edge_no;
    bus.in_hex_raw = 8'hFE;
    run(40);
    check_val("bounce_pulses", 16'(rises), 16'd1);
    check_val("bounce_edge", 16'(first_edge - base), 16'(DEB + 3));
    idle_gap();

    // Multi-key, release, then a single key
    start_win();
    bus.in_hex_raw = 8'hEE;
    run(30);
    check_val("multi_pulses", 16'(rises), 16'd0);
    bus.in_hex_raw = 8'hFF;
    run(20);
    base = edge_no;
    bus.in_hex_raw = 8'hF7;
    run(40);
    check_val("after_multi_pulses", 16'(rises), 16'd1);
    check_val("after_multi_edge", 16'(first_edge - base), 16'(DEB + 3));
    check_val("after_multi_hex", {8'b0, first_hex}, 16'h00F7);
    idle_gap();

    // Short press
    start_win();
    bus.in_hex_raw = 8'h7F;
    run(14);
    bus.in_hex_raw = 8'hFF;
    run(20);
    check_val("short_pulses", 16'(rises), 16'd0);
    idle_gap();

    // Reset in the middle of debouncing
    start_win();
    bus.in_hex_raw = 8'h7F;
    run(9);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    base = edge_no;
    run(40);
    check_val("mid_rst_pulses", 16'(rises), 16'd1);
    check_val("mid_rst_edge", 16'(first_edge - base), 16'(DEB + 3));
    idle_gap();

`ifdef REMOTE_HOLD_EN
    // Level hold until release reaches the FSM
    start_win();
    bus.in_hex_raw = 8'hDF;
    run(40);
    bus.in_hex_raw = 8'hFF;
    run(10);
    check_val("hold_pulses", 16'(rises), 16'd1);
    check_val("hold_start", 16'(first_edge), 16'(DEB + 3));
    check_val("hold_end", 16'(last_edge), 16'd42);
    idle_gap();
`endif

    // Randomized segments: idle, single keys, multi keys, short bounces, resets
    repeat (250) begin
      pick = $urandom_range(0, 99);
      if (pick < 40) begin
        bus.in_hex_raw = 8'hFF;
      end else if (pick < 80) begin
        one_hot = 8'h01 << $urandom_range(0, 7);
        bus.in_hex_raw = ~one_hot;
      end else begin
        multi = 8'($urandom);
        while ($countones(~multi) < 2) multi = 8'($urandom);
        bus.in_hex_raw = multi;
      end
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
      seg_len = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 40);
      run(seg_len);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
